// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: exception bit positions
// and MMIO register offsets within the 16-byte window.
package dmem_pkg;

  localparam int EXC_BADREQ   = 0;
  localparam int EXC_RANGE    = 1;
  localparam int EXC_OVERFLOW = 2;

  localparam logic [3:0] OFF_TX_DATA = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_CYCLES  = 4'h8;

endpackage

// File: rtl/console_fifo.sv
// Synchronous circular byte FIFO for the console TX path. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
module console_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_do_pop;
  logic          w_do_push;

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-2:0]] <= i_data;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_data  = o_empty ? 8'h00 : r_mem[r_rd_ptr[PW-2:0]];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: word RAM plus MMIO console/status/cycles.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLES register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_read,
  input  logic                          req_write,
  input  logic                          req_disable,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  input  logic [3:0]                    req_be,
  output logic [31:0]                   rsp_rdata,
  output logic [2:0]                    rsp_exception,
  output logic                          con_valid,
  output logic [7:0]                    con_data,
  input  logic                          con_ready,
  output logic [$clog2(FIFO_DEPTH):0]   con_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [31:0]           r_rsp_rdata;
  logic [2:0]            r_rsp_exc;

  logic                  w_active;
  logic                  w_in_ram;
  logic                  w_in_mmio;
  logic [3:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [2:0]            w_exc;
  logic                  w_ok;
  logic                  w_ram_we;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [LW-1:0]         w_level;
  logic [31:0]           w_rdata;
  logic [31:0]           w_cycles;

  assign w_active  = (req_read || req_write) && !req_disable;
  assign w_in_ram  = (req_addr[31:ADDR_WIDTH+2] == '0);
  assign w_in_mmio = (req_addr[31:4] == MMIO_BASE[31:4]);
  assign w_off     = req_addr[3:0];
  assign w_idx     = req_addr[ADDR_WIDTH+1:2];

  always_comb begin
    w_exc = '0;
    w_exc[EXC_BADREQ]   = (req_addr[1:0] != 2'b00) || (req_read && req_write);
    w_exc[EXC_RANGE]    = !w_in_ram && !w_in_mmio;
    w_exc[EXC_OVERFLOW] = req_write && w_in_mmio && (w_off == OFF_TX_DATA) &&
                          w_full && !w_pop;
  end

  // Any exception, or a request landing in a reset cycle, leaves all state untouched.
  assign w_ok     = w_active && (w_exc == '0) && !rst;
  assign w_ram_we = w_ok && req_write && w_in_ram;
  assign w_push   = w_ok && req_write && w_in_mmio && (w_off == OFF_TX_DATA) && req_be[0];

  // Console sink handshake: a byte moves on every clock edge where con_valid
  // and con_ready are both high; con_data holds steady while con_valid waits.
  assign w_pop = con_valid && con_ready;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (rst) r_cycles <= '0;
    else     r_cycles <= r_cycles + 32'd1;
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  // MMIO reads see register values from before this cycle's updates.
  always_comb begin
    w_rdata = '0;
    if (w_active && req_read && (w_exc == '0)) begin
      if (w_in_ram) begin
        w_rdata = r_mem[w_idx];
      end else begin
        case (w_off)
          OFF_STATUS: w_rdata = {{(32-LW-2){1'b0}}, w_full, w_empty, w_level};
          OFF_CYCLES: w_rdata = w_cycles;
          default:    w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= '0;
      r_rsp_exc   <= '0;
    end else begin
      r_rsp_rdata <= w_rdata;
      r_rsp_exc   <= w_active ? w_exc : 3'b000;
    end
  end

  console_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (req_wdata[7:0]),
    .i_pop   (w_pop),
    .o_data  (con_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign con_valid     = !w_empty;
  assign con_level     = w_level;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_exception = r_rsp_exc;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: RAM byte enables, exceptions,
// console FIFO flow, CYCLES register and reset flush.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic        req_disable = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_exception;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;
  logic [2:0]  con_level;

  logic [34:0] exp_q[$];
  logic [7:0]  con_exp[$];
  logic [7:0]  rx_q[$];
  logic [31:0] tb_cyc;
  int          n_vec = 0;
  int          n_err = 0;

  dmem_responder #(
    .ADDR_WIDTH(10),
    .FIFO_DEPTH(4),
    .MMIO_BASE (MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_disable   (req_disable),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .rsp_rdata     (rsp_rdata),
    .rsp_exception (rsp_exception),
    .con_valid     (con_valid),
    .con_data      (con_data),
    .con_ready     (con_ready),
    .con_level     (con_level)
  );

  // Clock / reset-related bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  always @(posedge clk) begin
    if (!rst && con_valid && con_ready) rx_q.push_back(con_data);
  end

  // Driver: one request per call, applied for exactly one clock edge.
  task automatic issue(input logic rd, input logic wr, input logic dis,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_d,
                       input logic [2:0] exp_e);
    @(negedge clk);
    req_read = rd; req_write = wr; req_disable = dis;
    req_addr = addr; req_wdata = wdata; req_be = be;
    exp_q.push_back({exp_d, exp_e});
    @(posedge clk);
    #1;
    req_read = 1'b0; req_write = 1'b0; req_disable = 1'b0; req_be = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    n_vec++; if (rsp_exception !== 3'b000) begin n_err++; $display("FAIL reset_exc: got %b want 000", rsp_exception); end
    n_vec++; if (con_valid !== 1'b0) begin n_err++; $display("FAIL reset_con_valid: got %b want 0", con_valid); end
    n_vec++; if (con_level !== 3'd0) begin n_err++; $display("FAIL reset_con_level: got %0d want 0", con_level); end
    n_vec++; if (con_data !== 8'h00) begin n_err++; $display("FAIL reset_con_data: got %h want 00", con_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ram();
    logic [34:0] exp;
    logic [31:0] base, upd, mrg;
    logic [3:0]  be;
    issue(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL ram_wr_full: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL ram_wr_byte: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h12345678, 4'b0000, 32'h0, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL ram_wr_be0: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL ram_rd_merge: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    for (int i = 0; i < 6; i++) begin
      base = $urandom;
      upd  = $urandom;
      be   = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) mrg[8*b +: 8] = be[b] ? upd[8*b +: 8] : base[8*b +: 8];
      issue(1'b0, 1'b1, 1'b0, (64 + i) * 4, base, 4'b1111, 32'h0, 3'b000);
      exp = exp_q.pop_front(); n_vec++;
      if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL ram_rnd_base[%0d]: got %h want %h", i, {rsp_rdata, rsp_exception}, exp); end
      issue(1'b0, 1'b1, 1'b0, (64 + i) * 4, upd, be, 32'h0, 3'b000);
      exp = exp_q.pop_front(); n_vec++;
      if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL ram_rnd_upd[%0d]: got %h want %h", i, {rsp_rdata, rsp_exception}, exp); end
      issue(1'b1, 1'b0, 1'b0, (64 + i) * 4, 32'h0, 4'($urandom_range(0, 15)), mrg, 3'b000);
      exp = exp_q.pop_front(); n_vec++;
      if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL ram_rnd_rd[%0d]: got %h want %h", i, {rsp_rdata, rsp_exception}, exp); end
    end
  endtask

  task automatic test_exceptions();
    logic [34:0] exp;
    logic        t_rd [13] = '{1, 1, 1, 1, 0, 1, 1, 0, 1, 0, 1, 1, 1};
    logic        t_wr [13] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
    logic        t_dis[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] t_adr[13] = '{32'h12, 32'h1000, 32'h10, 32'h1001, 32'h11, 32'h12,
                               MB + 32'hC, MB + 32'h4, MB, 32'h2000_0000, 32'h10,
                               MB + 32'h10, MB - 32'h4};
    logic [31:0] t_d  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEAA, 0, 0};
    logic [2:0]  t_e  [13] = '{3'b001, 3'b010, 3'b001, 3'b011, 3'b001, 3'b000, 3'b000,
                               3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010};
    for (int i = 0; i < 13; i++) begin
      issue(t_rd[i], t_wr[i], t_dis[i], t_adr[i], 32'hFFFF_FFFF, 4'b1111, t_d[i], t_e[i]);
      exp = exp_q.pop_front(); n_vec++;
      if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL exc[%0d]: got %h want %h", i, {rsp_rdata, rsp_exception}, exp); end
    end
  endtask

  task automatic test_console();
    logic [34:0] exp;
    con_ready = 1'b0;
    rx_q.delete();
    con_exp.delete();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 1'b0, MB, 32'h41 + i, 4'b0001, 32'h0, 3'b000);
      con_exp.push_back(8'(8'h41 + i));
      exp = exp_q.pop_front(); n_vec++;
      if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL con_push[%0d]: got %h want %h", i, {rsp_rdata, rsp_exception}, exp); end
    end
    n_vec++; if (con_level !== 3'd4) begin n_err++; $display("FAIL con_level_full: got %0d want 4", con_level); end
    n_vec++; if (con_data !== 8'h41) begin n_err++; $display("FAIL con_head: got %h want 41", con_data); end
    issue(1'b1, 1'b0, 1'b0, MB + 32'h4, 32'h0, 4'b0000, 32'h14, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL con_status_full: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    issue(1'b0, 1'b1, 1'b0, MB, 32'h58, 4'b0001, 32'h0, 3'b100);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL con_overflow: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    n_vec++; if (con_level !== 3'd4) begin n_err++; $display("FAIL con_level_ovf: got %0d want 4", con_level); end
    con_ready = 1'b1;
    issue(1'b0, 1'b1, 1'b0, MB, 32'h45, 4'b0001, 32'h0, 3'b000);
    con_exp.push_back(8'h45);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL con_push_pop_full: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    n_vec++; if (con_level !== 3'd4) begin n_err++; $display("FAIL con_level_pp: got %0d want 4", con_level); end
    for (int k = 0; k < 20; k++) begin
      if (!con_valid) break;
      @(posedge clk); #1;
    end
    n_vec++; if (con_valid !== 1'b0) begin n_err++; $display("FAIL con_drain_timeout: got valid %b want 0", con_valid); end
    issue(1'b0, 1'b1, 1'b0, MB, 32'h5A, 4'b0001, 32'h0, 3'b000);
    con_exp.push_back(8'h5A);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL con_push_empty: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    n_vec++; if (con_level !== 3'd1 || con_data !== 8'h5A) begin n_err++; $display("FAIL con_push_pop_empty: got level %0d data %h want 1 5a", con_level, con_data); end
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL con_idle: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    con_ready = 1'b0;
    n_vec++; if (rx_q.size() != con_exp.size()) begin n_err++; $display("FAIL con_rx_count: got %0d want %0d", rx_q.size(), con_exp.size()); end
    while (rx_q.size() > 0 && con_exp.size() > 0) begin
      logic [7:0] got, want;
      got = rx_q.pop_front();
      want = con_exp.pop_front();
      n_vec++; if (got !== want) begin n_err++; $display("FAIL con_rx_order: got %h want %h", got, want); end
    end
  endtask

  task automatic test_cycles();
    logic [34:0] exp;
    logic [31:0] c1, c2;
    issue(1'b1, 1'b0, 1'b0, MB + 32'h8, 32'h0, 4'b1111, CYC_EN ? tb_cyc : 32'h0, 3'b000);
    c1 = rsp_rdata;
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL cyc_rd1: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    issue(1'b0, 1'b1, 1'b0, MB + 32'h8, 32'h0, 4'b1111, 32'h0, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL cyc_wr_ignored: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 3'b000);
      exp = exp_q.pop_front(); n_vec++;
      if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL cyc_idle[%0d]: got %h want %h", i, {rsp_rdata, rsp_exception}, exp); end
    end
    issue(1'b1, 1'b0, 1'b0, MB + 32'h8, 32'h0, 4'b1111, CYC_EN ? tb_cyc : 32'h0, 3'b000);
    c2 = rsp_rdata;
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL cyc_rd2: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    n_vec++; if (c2 - c1 !== (CYC_EN ? 32'd5 : 32'd0)) begin n_err++; $display("FAIL cyc_delta: got %0d want %0d", c2 - c1, CYC_EN ? 5 : 0); end
  endtask

  task automatic test_reset_flush();
    logic [34:0] exp;
    con_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 1'b1, 1'b0, MB, 32'h61 + i, 4'b0001, 32'h0, 3'b000);
      exp = exp_q.pop_front(); n_vec++;
      if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL flush_push[%0d]: got %h want %h", i, {rsp_rdata, rsp_exception}, exp); end
    end
    n_vec++; if (con_level !== 3'd2) begin n_err++; $display("FAIL flush_level_pre: got %0d want 2", con_level); end
    rst = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h5555_5555, 4'b1111, 32'h0, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL flush_rsp: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
    n_vec++; if (con_valid !== 1'b0 || con_level !== 3'd0) begin n_err++; $display("FAIL flush_fifo: got valid %b level %0d want 0 0", con_valid, con_level); end
    rst = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEAA, 3'b000);
    exp = exp_q.pop_front(); n_vec++;
    if ({rsp_rdata, rsp_exception} !== exp) begin n_err++; $display("FAIL flush_discard_wr: got %h want %h", {rsp_rdata, rsp_exception}, exp); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_exceptions();
    test_console();
    test_cycles();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's MEM stage. It accepts at most one read or write request per cycle and returns read data and a 3-bit memory exception one cycle later, matching the MEM stage's fixed-latency expectation. Behind it sit a word-addressed RAM with byte-write enables and a small MMIO window. The window holds a console TX FIFO drained by a host-side valid/ready sink, a status register and a free-running cycle counter.

## Interface

- ADDR_WIDTH, 10: RAM depth is 2^ADDR_WIDTH 32-bit words, based at address 0.
- FIFO_DEPTH, 4: console FIFO entries; must be a power of two, at least 2.
- MMIO_BASE, 32'hFFFF_0000: base of the MMIO window (16 bytes).

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_read  in  1  read request this cycle.
- req_write  in  1  write request this cycle.
- req_disable  in  1  squash; when high, the request is ignored and the response is all-zero.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte write enables; bit i selects req_wdata[8i+7:8i].
- rsp_rdata  out  32  read data, valid the cycle after the request.
- rsp_exception  out  3  exception bits, valid the cycle after the request.
- con_valid  out  1  console FIFO non-empty.
- con_data  out  8  FIFO head byte.
- con_ready  in  1  sink accepts the head byte when con_valid && con_ready.
- con_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation

- A request is active when (req_read | req_write) && !req_disable.
- Exception bits:
  - bit0 BADREQ: req_addr[1:0] != 0, or req_read && req_write.
  - bit1 RANGE: the address is neither in RAM (addr < 4·2^ADDR_WIDTH) nor in the MMIO window.
  - bit2 OVERFLOW: a write to TX_DATA while the FIFO is full and no pop occurs that cycle.
- Any exception bit set: no state changes (no RAM write, no FIFO push) and rsp_rdata = 0.
- RAM read returns the full word regardless of req_be. RAM write updates only the enabled bytes; req_be = 0 is a legal no-op.
- MMIO offsets:
  - +0 TX_DATA: a write pushes req_wdata[7:0] if req_be[0]; a read returns 0.
  - +4 STATUS: read returns {zero-fill, full, empty, con_level}; a write is ignored without exception.
  - +8 CYCLES: 32-bit count of cycles since reset, wrapping at 2^32; a write is ignored.
  - +C: reads 0, writes are ignored.
- FIFO push and pop in the same cycle:
  - full: accepted, occupancy unchanged.
  - empty: con_valid is still low this cycle, so only the push happens.
- The MMIO read of STATUS or CYCLES reflects the value before any same-cycle update.

## Timing

- Response latency is exactly 1 cycle. rsp_rdata and rsp_exception are registered.
- Both outputs are 0 in any cycle that follows a non-active request.
- con_valid, con_data and con_level are driven from registered FIFO state. A pushed byte is visible the cycle after the push.
- Reset values:
  - rsp_rdata = 0, rsp_exception = 0.
  - FIFO empty: con_valid = 0, con_level = 0, con_data = 0.
  - CYCLES = 0.
  - RAM contents are not reset.
- A reset asserted mid-operation drops the in-flight response and flushes the FIFO.
- A request issued in the same cycle as reset is discarded.

## Configuration

- DMEM_CYCLE_COUNTER_EN
  - Defined: the CYCLES register exists as specified.
  - Undefined: no counter is instantiated, and a read of +8 returns 0 without exception.

## Structure

- Shared package dmem_pkg holds:
  - exception bit indices EXC_BADREQ = 0, EXC_RANGE = 1, EXC_OVERFLOW = 2;
  - MMIO offsets OFF_TX_DATA, OFF_STATUS, OFF_CYCLES.
- One sub-module, console_fifo. It is a synchronous circular FIFO with push/pop, full/empty and level outputs, using pointers of $clog2(FIFO_DEPTH)+1 bits.
- Address decode, the RAM, the response register and the counter stay in dmem_responder.

## Test plan

- Write 0xDEADBEEF to 0x10 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read 0x10 → rsp_rdata = 0xDEADBEAA one cycle later, rsp_exception = 0.
- Read 0x12 → rsp_exception = 3'b001, rsp_rdata = 0. Read 0x0000_1000 with ADDR_WIDTH = 10 → rsp_exception = 3'b010.
- With con_ready = 0, push 'A'..'D' to TX_DATA → con_level = 4, STATUS reads full = 1. A fifth push → rsp_exception = 3'b100 and the level stays 4.
- With the FIFO full, hold con_ready = 1 and push 'E' in the same cycle → no exception. The sink then receives A, B, C, D, E in order.
- Read CYCLES at cycle N after reset, then again 5 cycles later → the values differ by 5. Without DMEM_CYCLE_COUNTER_EN → both reads return 0.
- req_read with req_disable = 1 at a misaligned address → rsp_exception = 0. A reset asserted with 2 bytes queued → con_valid = 0 and con_level = 0 the next cycle.
